// File: rtl/vga_pkg.sv
// Shared VGA raster constants, framebuffer address packing and the colour-bar table.
// STREAM_TEST_PATTERN_EN (see vga_frame_streamer) consumes bar_color().
package vga_pkg;

   localparam int H_TOTAL  = 800;
   localparam int HS_START = 656;
   localparam int HS_END   = 751;
   localparam int V_TOTAL  = 525;
   localparam int VS_START = 490;
   localparam int VS_END   = 491;
   localparam int WIN_W    = 320;
   localparam int WIN_H    = 240;

   localparam logic [23:0] BAR_COLORS [8] = '{
      24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
      24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
   };

   function automatic logic [16:0] pack_addr(input logic [7:0] y, input logic [8:0] x);
      return {y, x};
   endfunction

   // Bars are 40 pixels wide; the window is 320 wide so the index never exceeds 7.
   function automatic logic [23:0] bar_color(input logic [8:0] x);
      logic [8:0] idx;
      idx = x / 9'd40;
      return BAR_COLORS[idx[2:0]];
   endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Raster counters h/v with the raw (unaligned) sync, window, origin and swap-sample flags.
module vga_timing_counter
   import vga_pkg::*;
#(
   parameter int H_TOT    = H_TOTAL,
   parameter int HS_FIRST = HS_START,
   parameter int HS_LAST  = HS_END,
   parameter int V_TOT    = V_TOTAL,
   parameter int VS_FIRST = VS_START,
   parameter int VS_LAST  = VS_END,
   parameter int WIN_X    = WIN_W,
   parameter int WIN_Y    = WIN_H
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic [16:0] o_addr,
   output logic        o_window,
   output logic        o_hsync_n,
   output logic        o_vsync_n,
   output logic        o_origin,
   output logic        o_swap_pt
);

   localparam logic [9:0] H_LAST  = 10'(H_TOT - 1);
   localparam logic [9:0] V_LAST  = 10'(V_TOT - 1);
   localparam logic [9:0] HS_LO   = 10'(HS_FIRST);
   localparam logic [9:0] HS_HI   = 10'(HS_LAST);
   localparam logic [9:0] VS_LO   = 10'(VS_FIRST);
   localparam logic [9:0] VS_HI   = 10'(VS_LAST);
   localparam logic [9:0] X_LIMIT = 10'(WIN_X);
   localparam logic [9:0] Y_LIMIT = 10'(WIN_Y);

   logic [9:0] r_h_cnt;
   logic [9:0] r_v_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_h_cnt <= 10'd0;
         r_v_cnt <= 10'd0;
      end else if (r_h_cnt == H_LAST) begin
         r_h_cnt <= 10'd0;
         r_v_cnt <= (r_v_cnt == V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
      end else begin
         r_h_cnt <= r_h_cnt + 10'd1;
      end
   end

   assign o_addr    = pack_addr(r_v_cnt[7:0], r_h_cnt[8:0]);
   assign o_window  = (r_h_cnt < X_LIMIT) && (r_v_cnt < Y_LIMIT);
   assign o_hsync_n = !((r_h_cnt >= HS_LO) && (r_h_cnt <= HS_HI));
   assign o_vsync_n = !((r_v_cnt >= VS_LO) && (r_v_cnt <= VS_HI));
   assign o_origin  = (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);
   // First column of the first line past the window: nothing reads the framebuffer here.
   assign o_swap_pt = (r_h_cnt == 10'd0) && (r_v_cnt == Y_LIMIT);

endmodule

// File: rtl/vga_frame_streamer.sv
// VGA pixel-stream source: 2-stage framebuffer read pipe, sync alignment and buffer swap.
// Define STREAM_TEST_PATTERN_EN to replace framebuffer data with eight vertical colour bars.
module vga_frame_streamer
   import vga_pkg::*;
#(
   parameter int H_VISIBLE = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int SRC_W     = WIN_W,
   parameter int SRC_H     = WIN_H
) (
   input  logic        clk,
   input  logic        rst,
   output logic [16:0] fb_addr,
   input  logic [23:0] fb_rdata,
   output logic        fb_sel,
   input  logic        fb_swap_req,
   output logic        fb_swap_ack,
   output logic [23:0] pixel_out,
   output logic [16:0] pixel_addr,
   output logic        active_area,
   output logic        hsync,
   output logic        vsync,
   output logic        frame_start
);

   logic [16:0] w_addr;
   logic        w_window, w_hsync_n, w_vsync_n, w_origin, w_swap_pt;

   logic [16:0] r_fb_addr, r_pix_addr;
   logic        r_act1, r_hs1, r_vs1, r_org1;
   logic        r_act2, r_hs2, r_vs2, r_org2;
   logic        r_fb_sel, r_swap_ack;

   vga_timing_counter #(
      .H_TOT    (H_VISIBLE + H_FP + H_SYNC + H_BP),
      .HS_FIRST (H_VISIBLE + H_FP),
      .HS_LAST  (H_VISIBLE + H_FP + H_SYNC - 1),
      .V_TOT    (V_VISIBLE + V_FP + V_SYNC + V_BP),
      .VS_FIRST (V_VISIBLE + V_FP),
      .VS_LAST  (V_VISIBLE + V_FP + V_SYNC - 1),
      .WIN_X    (SRC_W),
      .WIN_Y    (SRC_H)
   ) u_timing (
      .i_clk     (clk),
      .i_rst     (rst),
      .o_addr    (w_addr),
      .o_window  (w_window),
      .o_hsync_n (w_hsync_n),
      .o_vsync_n (w_vsync_n),
      .o_origin  (w_origin),
      .o_swap_pt (w_swap_pt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fb_addr <= 17'd0;
         r_act1    <= 1'b0;
         r_hs1     <= 1'b1;
         r_vs1     <= 1'b1;
         r_org1    <= 1'b0;
      end else begin
         if (w_window) begin
            r_fb_addr <= w_addr;
         end
         r_act1 <= w_window;
         r_hs1  <= w_hsync_n;
         r_vs1  <= w_vsync_n;
         r_org1 <= w_origin;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pix_addr <= 17'd0;
         r_act2     <= 1'b0;
         r_hs2      <= 1'b1;
         r_vs2      <= 1'b1;
         r_org2     <= 1'b0;
      end else begin
         r_pix_addr <= r_act1 ? r_fb_addr : 17'd0;
         r_act2     <= r_act1;
         r_hs2      <= r_hs1;
         r_vs2      <= r_vs1;
         r_org2     <= r_org1;
      end
   end

   // Swap is only taken at the blank-start sample point, so fb_sel is stable across the window.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fb_sel   <= 1'b0;
         r_swap_ack <= 1'b0;
      end else if (w_swap_pt && fb_swap_req) begin
         r_fb_sel   <= ~r_fb_sel;
         r_swap_ack <= 1'b1;
      end else begin
         r_swap_ack <= 1'b0;
      end
   end

`ifdef STREAM_TEST_PATTERN_EN
   logic [23:0] r_bar1, r_bar2;
   logic        w_unused_rdata;

   assign w_unused_rdata = ^fb_rdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_bar1 <= 24'd0;
         r_bar2 <= 24'd0;
      end else begin
         r_bar1 <= bar_color(w_addr[8:0]);
         r_bar2 <= r_act1 ? r_bar1 : 24'd0;
      end
   end

   assign pixel_out = r_bar2;
`else
   // The RAM output arrives in the same cycle as the stage-2 flags, so it is gated, not re-registered.
   assign pixel_out = r_act2 ? fb_rdata : 24'd0;
`endif

   assign fb_addr     = r_fb_addr;
   assign fb_sel      = r_fb_sel;
   assign fb_swap_ack = r_swap_ack;
   assign pixel_addr  = r_pix_addr;
   assign active_area = r_act2;
   assign hsync       = r_hs2;
   assign vsync       = r_vs2;
   assign frame_start = r_org2;

endmodule

// File: tb/tb_vga_frame_streamer.sv
// Directed bench for vga_frame_streamer: full 800-column lines with a shortened 16-line frame
// (7 window lines, vsync on lines 11..12) so three frames and a mid-frame reset fit the run.
module tb_vga_frame_streamer;

   localparam int HT    = 800;
   localparam int VT    = 16;
   localparam int FRAME = HT * VT;
   localparam int SW    = 320;
   localparam int SH    = 7;
   localparam int K_END = 3 * FRAME + 4 * HT + 200;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [16:0] fb_addr;
   logic [23:0] fb_rdata = 24'd0;
   logic        fb_sel;
   logic        fb_swap_req = 1'b0;
   logic        fb_swap_ack;
   logic [23:0] pixel_out;
   logic [16:0] pixel_addr;
   logic        active_area, hsync, vsync, frame_start;

   int n_vec = 0;
   int n_miscompare = 0;

   vga_frame_streamer #(
      .V_VISIBLE (10),
      .V_FP      (1),
      .V_SYNC    (2),
      .V_BP      (3),
      .SRC_H     (SH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .fb_addr     (fb_addr),
      .fb_rdata    (fb_rdata),
      .fb_sel      (fb_sel),
      .fb_swap_req (fb_swap_req),
      .fb_swap_ack (fb_swap_ack),
      .pixel_out   (pixel_out),
      .pixel_addr  (pixel_addr),
      .active_area (active_area),
      .hsync       (hsync),
      .vsync       (vsync),
      .frame_start (frame_start)
   );

   always #20 clk = ~clk;

   // Registered RAM model, 1-cycle read latency.
   always @(posedge clk) fb_rdata <= {8'h12, fb_addr[16:9], fb_addr[7:0]};

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miscompare++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] exp_pix(input int x, input int y);
      logic [7:0] xx, yy;
      xx = 8'(x);
      yy = 8'(y);
`ifdef STREAM_TEST_PATTERN_EN
      case (x / 40)
         0:       return 24'hFFFFFF;
         1:       return 24'hFFFF00;
         2:       return 24'h00FFFF;
         3:       return 24'h00FF00;
         4:       return 24'hFF00FF;
         5:       return 24'hFF0000;
         6:       return 24'h0000FF;
         default: return 24'h000000;
      endcase
`else
      return {8'h12, yy, xx};
`endif
   endfunction

   initial begin
      int p, h, v;
      logic exp_act, exp_hs, exp_vs, exp_fs;
      int n_act = 0, n_hs = 0, n_vs = 0, n_fs = 0, n_ack = 0;
      int first_hs = -1, first_vs = -1;
      int err_act = 0, err_pix = 0, err_addr = 0, err_blank = 0;
      int err_hs = 0, err_vs = 0, err_fs = 0;
      int ack_k [3];
      logic sel_a = 1'b1, sel_b = 1'b0;

      ack_k = '{0, 0, 0};

      repeat (5) @(negedge clk);
      check_val("rst_fb_addr", 32'(fb_addr), 32'h0);
      check_val("rst_fb_sel", 32'(fb_sel), 32'h0);
      check_val("rst_ack", 32'(fb_swap_ack), 32'h0);
      check_val("rst_pixel_out", 32'(pixel_out), 32'h0);
      check_val("rst_pixel_addr", 32'(pixel_addr), 32'h0);
      check_val("rst_active", 32'(active_area), 32'h0);
      check_val("rst_hsync", 32'(hsync), 32'h1);
      check_val("rst_vsync", 32'(vsync), 32'h1);
      check_val("rst_frame_start", 32'(frame_start), 32'h0);
      rst = 1'b0;

      // At negedge k after release the counters sit at linear position k; outputs show k-2.
      for (int k = 1; k <= K_END; k++) begin
         @(negedge clk);
         p = k - 2;
         h = (p < 0) ? 0 : p % HT;
         v = (p < 0) ? 0 : (p / HT) % VT;
         if (p >= 0) begin
            exp_act = (h < SW) && (v < SH);
            exp_hs  = !((h >= 656) && (h <= 751));
            exp_vs  = !((v >= 11) && (v <= 12));
            exp_fs  = (h == 0) && (v == 0);
            if (active_area !== exp_act) err_act++;
            if (exp_act) begin
               if (pixel_addr !== 17'(v * 512 + h)) err_addr++;
               if (pixel_out !== exp_pix(h, v)) err_pix++;
            end else if ((pixel_out !== 24'd0) || (pixel_addr !== 17'd0)) begin
               err_blank++;
            end
            if (hsync !== exp_hs) err_hs++;
            if (vsync !== exp_vs) err_vs++;
            if (frame_start !== exp_fs) err_fs++;
            if (p < FRAME) begin
               if (active_area) n_act++;
               if (!hsync) begin
                  n_hs++;
                  if (first_hs < 0) first_hs = p;
               end
               if (!vsync) begin
                  n_vs++;
                  if (first_vs < 0) first_vs = p;
               end
            end
         end
         if (frame_start) n_fs++;

         if (k == 1) check_val("rel_k1_active", 32'(active_area), 32'h0);
         if (k == 2) begin
            check_val("rel_k2_active", 32'(active_area), 32'h1);
            check_val("rel_k2_pixel_addr", 32'(pixel_addr), 32'h0);
            check_val("rel_k2_frame_start", 32'(frame_start), 32'h1);
         end
`ifdef STREAM_TEST_PATTERN_EN
         if (k == 2)   check_val("bar_x0", 32'(pixel_out), 32'hFFFFFF);
         if (k == 47)  check_val("bar_x45", 32'(pixel_out), 32'hFFFF00);
         if (k == 321) check_val("bar_x319", 32'(pixel_out), 32'h000000);
         if (k == 4321) check_val("y5_x319_pix", 32'(pixel_out), 32'h000000);
`else
         if (k == 4321) check_val("y5_x319_pix", 32'(pixel_out), 32'h12053F);
`endif
         if (k == 4321) check_val("y5_x319_addr", 32'(pixel_addr), 32'h00B3F);
         if (k == 4322) begin
            check_val("y5_x320_active", 32'(active_area), 32'h0);
            check_val("y5_x320_pix", 32'(pixel_out), 32'h0);
         end

         if (k == 5600) sel_a = fb_sel;
         if (k == 5601) sel_b = fb_sel;
         if (fb_swap_ack) begin
            if (n_ack < 3) ack_k[n_ack] = k;
            n_ack++;
            if (n_ack == 3) fb_swap_req = 1'b0;
         end
         if (k == 3 * HT) fb_swap_req = 1'b1;
      end

      check_val("frame_active_cycles", 32'(n_act), 32'(SW * SH));
      check_val("frame_hsync_low", 32'(n_hs), 32'(96 * VT));
      check_val("hsync_first_low", 32'(first_hs), 32'd656);
      check_val("frame_vsync_low", 32'(n_vs), 32'd1600);
      check_val("vsync_first_low", 32'(first_vs), 32'd8800);
      check_val("active_errs", 32'(err_act), 32'h0);
      check_val("addr_errs", 32'(err_addr), 32'h0);
      check_val("pixel_errs", 32'(err_pix), 32'h0);
      check_val("blank_errs", 32'(err_blank), 32'h0);
      check_val("hsync_errs", 32'(err_hs), 32'h0);
      check_val("vsync_errs", 32'(err_vs), 32'h0);
      check_val("frame_start_errs", 32'(err_fs), 32'h0);
      check_val("frame_start_count", 32'(n_fs), 32'd4);
      check_val("ack_cycles", 32'(n_ack), 32'd3);
      check_val("ack1_pos", 32'(ack_k[0]), 32'd5601);
      check_val("ack2_period", 32'(ack_k[1] - ack_k[0]), 32'(FRAME));
      check_val("ack3_period", 32'(ack_k[2] - ack_k[1]), 32'(FRAME));
      check_val("sel_before_swap", 32'(sel_a), 32'h0);
      check_val("sel_after_swap", 32'(sel_b), 32'h1);
      check_val("sel_before_rst", 32'(fb_sel), 32'h1);

      // Counters now at line 4, x=200: reset mid-frame.
      rst = 1'b1;
      @(negedge clk);
      check_val("mid_rst_fb_sel", 32'(fb_sel), 32'h0);
      check_val("mid_rst_fb_addr", 32'(fb_addr), 32'h0);
      check_val("mid_rst_active", 32'(active_area), 32'h0);
      check_val("mid_rst_pixel_out", 32'(pixel_out), 32'h0);
      rst = 1'b0;
      @(negedge clk);
      check_val("mid_rel_k1_active", 32'(active_area), 32'h0);
      @(negedge clk);
      check_val("mid_rel_k2_active", 32'(active_area), 32'h1);
      check_val("mid_rel_k2_pixel_addr", 32'(pixel_addr), 32'h0);
      check_val("mid_rel_k2_frame_start", 32'(frame_start), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
      $finish;
   end

endmodule

// File: doc/vga_frame_streamer.md
# vga_frame_streamer

Pixel-stream source for the camera display path. Scans a 640x480@60 VGA raster at 25 MHz and reads the 320x240 RGB888 framebuffer for the top-left 320x240 window. Drives the per-pixel stream (`pixel_in`, `pixel_addr`, `active_area`, `vsync`) consumed by the 3x3 filter stages and the VGA output. Owns framebuffer double-buffer selection through a swap handshake.

## Interface
Parameters:
- `H_VISIBLE`, 640, visible columns
- `H_FP`, 16, horizontal front porch
- `H_SYNC`, 96, hsync pulse width
- `H_BP`, 48, horizontal back porch (total 800)
- `V_VISIBLE`, 480, visible lines
- `V_FP`, 10, vertical front porch
- `V_SYNC`, 2, vsync pulse width
- `V_BP`, 33, vertical back porch (total 525)
- `SRC_W`, 320, source width
- `SRC_H`, 240, source height

Ports:
- `clk` in 1: 25 MHz VGA clock; single clock domain
- `rst` in 1: synchronous, active-high reset
- `fb_addr` out 17: framebuffer read address {y[7:0], x[8:0]}
- `fb_rdata` in 24: framebuffer read data, registered RAM, 1-cycle latency
- `fb_sel` out 1: active read buffer
- `fb_swap_req` in 1: level request to toggle `fb_sel`
- `fb_swap_ack` out 1: 1-cycle pulse when the swap is taken
- `pixel_out` out 24: RGB888 pixel to filters; 0 outside the window
- `pixel_addr` out 17: {y[7:0], x[8:0]} aligned with `pixel_out`
- `active_area` out 1: high when `pixel_out` is a source pixel
- `hsync` out 1: active-low
- `vsync` out 1: active-low
- `frame_start` out 1: 1-cycle pulse aligned with pixel (0,0)

## Operation
- Counters `h_cnt` 0..799 and `v_cnt` 0..524. `h_cnt` wraps at 799 and then increments `v_cnt`. `v_cnt` wraps at 524 to 0 on the same cycle `h_cnt` wraps.
- Window condition: `h_cnt < SRC_W && v_cnt < SRC_H`. Stage 1 registers `fb_addr = {v_cnt[7:0], h_cnt[8:0]}` when inside the window. Outside the window `fb_addr` holds its last value.
- Stage 2 drives the outputs:
  - `pixel_out` = `fb_rdata` in the window, else 0.
  - `pixel_addr` = the stage-1 address in the window, else 0.
  - `active_area` = the window condition.
- Stage 1 and stage 2 together form a 2-stage delay line. `hsync`/`vsync` pass through it with the same latency as the window flag.
  - `hsync` low when `h_cnt` is in 656..751.
  - `vsync` low when `v_cnt` is in 490..491.
- Swap handshake, sampled only at `h_cnt==0 && v_cnt==SRC_H` (start of framebuffer blank):
  - If `fb_swap_req`=1: toggle `fb_sel` and pulse `fb_swap_ack` on the next cycle.
  - At most one swap per frame. The requester drops `fb_swap_req` after the ack. If the request is still high next frame, a second swap occurs.
  - A request raised mid-window waits for the sample point. `fb_sel` never changes while the window is being read.
- `frame_start` pulses with the stage-2 output of pixel (0,0).

## Timing
- Reset values:
  - Counters: 0.
  - Outputs: `fb_addr`=0, `fb_sel`=0, `fb_swap_ack`=0, `pixel_out`=0, `pixel_addr`=0, `active_area`=0, `hsync`=1, `vsync`=1, `frame_start`=0.
  - Pipeline registers clear to the blank state.
- Latency: counters at (h,v) in cycle t → `fb_addr` at t+1 → `pixel_out`/`pixel_addr`/`active_area`/syncs at t+2.
- First valid pixel after reset is release cycle + 2. Reset asserted mid-frame restarts the raster at (0,0) on the next cycle; no partial line completes.
- Window: 320 consecutive `active_area` cycles per line for lines 0..239. Then 480 idle cycles per line. Lines 240..524 are fully idle.
- `vsync` rising edge (end of line 491) precedes line 0 by 33 lines, giving downstream caches time to clear.

## Configuration
- `STREAM_TEST_PATTERN_EN`
  - **Defined:** `pixel_out` is replaced by eight 40-pixel vertical bars indexed by x/40: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000. `fb_rdata` is ignored. `fb_addr`, handshake and timing are unchanged.
  - **Undefined:** framebuffer data is passed through.

## Structure
- Shared package `vga_pkg`:
  - timing constants: totals, sync start/end, window size
  - the 17-bit address packing function
  - color-bar constant array
- One sub-module, `vga_timing_counter`. It owns `h_cnt`/`v_cnt`, the raw hsync/vsync/window flags and the swap sample point. The top level holds the 2-stage alignment pipe, the swap logic and the pattern mux.

## Test plan
- **Reset:** hold `rst` 5 cycles → every output at its reset value. Release → first `active_area`=1 exactly 2 cycles later with `pixel_addr`=0 and `frame_start`=1.
- **Data alignment:** RAM model returns `{8'h12, y, x[7:0]}` → each `pixel_out` matches its `pixel_addr`. Line y=5, x=319: `pixel_addr`=0x00B3F. Next cycle `active_area`=0, `pixel_out`=0.
- **Sync timing:** count one frame → hsync low 96 cycles starting at column 656+2. Vsync low for exactly 1600 cycles. 420000 cycles per frame.
- **Swap:** raise `fb_swap_req` at line 100 → `fb_swap_ack` pulses once at line 240 column 1. `fb_sel` 0→1 there. Hold req high → a second swap occurs one frame later.
- **Reset mid-frame:** `rst` at line 120, x=200 → next cycle counters at 0. Stream restarts at (0,0) 2 cycles after release. `fb_sel` returns to 0.
- **Pattern (macro defined):** x=0 → FFFFFF, x=45 → FFFF00, x=319 → 000000, independent of `fb_rdata`.
